// File: rtl/aud_dsp_gen2.sv
// Playback DSP between the recording SRAM and the DAC serialiser: one output sample per
// LR-clock falling edge, with fast / slow-hold / slow-linear play, reverse, end address and pause.
module aud_dsp_gen2 #(
   parameter int DW = 16,
   parameter int AW = 20,
   parameter int SW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_pause,
   input  logic          i_stop,
   input  logic [1:0]    i_mode,
   input  logic [SW-1:0] i_speed,
   input  logic          i_reverse,
   input  logic [AW-1:0] i_end_addr,
   input  logic          i_daclrck,
   input  logic [DW-1:0] i_sram_data,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_dac_data,
   output logic          o_dac_valid,
   output logic          o_busy,
   output logic          o_done
);
   localparam int LAT = DW + SW + 4;
   localparam int PW  = DW + SW;
   localparam int CW  = $clog2(LAT + 1);
   localparam logic [SW-1:0] SPD1 = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADR1 = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

   state_t        r_state;
   logic          r_lrck;
   logic [AW-1:0] r_addr;
   logic [SW-1:0] r_k;
   logic [SW-1:0] r_spd;
   logic          r_slow;
   logic          r_lin;
   logic          r_rev;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_a;
   logic          r_neg;
   logic [SW-1:0] r_rem;
   logic [PW-1:0] r_quo;
   logic          r_fin;
   logic [DW-1:0] r_dac_data;
   logic          r_dac_valid;
   logic          r_done;

   logic               w_tick;
   logic [SW-1:0]      w_spd;
   logic [AW-1:0]      w_nb;
   logic signed [DW:0] w_diff;
   logic signed [PW:0] w_prod;
   logic [PW-1:0]      w_mag;
   logic [SW:0]        w_shift;
   logic               w_ge;
   logic [DW-1:0]      w_qs;
   logic [DW-1:0]      w_sum;
   logic [SW-1:0]      w_kinc;
   logic               w_adv;
   logic [AW:0]        w_step;
   logic [AW:0]        w_next;
   logic               w_end;

   assign w_tick = r_lrck & ~i_daclrck;
   assign w_spd  = (i_speed == '0) ? SPD1 : i_speed;

   // Second fetch address, clamped at either end of the buffer.
   always_comb begin
      w_nb = r_addr;
      if (r_rev) begin
         if (r_addr != '0)
            w_nb = r_addr - ADR1;
      end else if (r_addr < i_end_addr) begin
         w_nb = r_addr + ADR1;
      end
   end

   assign o_sram_addr = (r_cnt == CW'(2)) ? w_nb : r_addr;

   assign w_diff = $signed({i_sram_data[DW-1], i_sram_data}) - $signed({r_a[DW-1], r_a});
   assign w_prod = $signed({{SW{w_diff[DW]}}, w_diff}) * $signed({{(DW+1){1'b0}}, r_k});
   assign w_mag  = w_prod[PW] ? PW'(-w_prod) : w_prod[PW-1:0];

   assign w_shift = {r_rem, r_quo[PW-1]};
   assign w_ge    = (w_shift >= {1'b0, r_spd});

   // The true sum always lies between A and B, so modular DW-bit arithmetic is exact.
   assign w_qs  = r_neg ? (-r_quo[DW-1:0]) : r_quo[DW-1:0];
   assign w_sum = r_a + w_qs;

   assign w_kinc = r_k + SPD1;
   assign w_adv  = ~r_slow | (w_kinc == r_spd);
   assign w_step = r_slow ? (AW+1)'(w_adv) : (AW+1)'(r_spd);
   assign w_next = r_rev ? ({1'b0, r_addr} - w_step) : ({1'b0, r_addr} + w_step);
   assign w_end  = w_adv & (r_rev ? w_next[AW] : (w_next > {1'b0, i_end_addr}));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_lrck      <= 1'b0;
         r_addr      <= '0;
         r_k         <= '0;
         r_spd       <= SPD1;
         r_slow      <= 1'b0;
         r_lin       <= 1'b0;
         r_rev       <= 1'b0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_neg       <= 1'b0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_fin       <= 1'b0;
         r_dac_data  <= '0;
         r_dac_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_lrck      <= i_daclrck;
         r_dac_valid <= 1'b0;
         r_done      <= 1'b0;
         if (i_stop || r_fin) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_k        <= '0;
            r_dac_data <= '0;
            r_cnt      <= '0;
            r_fin      <= 1'b0;
            r_done     <= r_fin & ~i_stop;
         end else if (i_pause) begin
            if (r_state == S_PLAY) begin
               r_state    <= S_PAUSE;
               r_cnt      <= '0;
               r_dac_data <= '0;
            end
         end else if (i_start && r_state != S_PLAY) begin
            r_state <= S_PLAY;
            if (r_state == S_IDLE) begin
               r_addr <= i_reverse ? i_end_addr : '0;
               r_k    <= '0;
            end
         end else if (r_state == S_PLAY) begin
            if (r_cnt == '0) begin
               if (w_tick) begin
                  r_cnt <= CW'(1);
                  // Play settings only change on a source-sample boundary.
                  if (r_k == '0) begin
                     r_spd  <= w_spd;
                     r_slow <= (i_mode == 2'd1) || (i_mode == 2'd2);
                     r_lin  <= (i_mode == 2'd2);
                     r_rev  <= i_reverse;
                  end
               end
            end else begin
               r_cnt <= (r_cnt == CW'(LAT-1)) ? '0 : r_cnt + CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_a <= i_sram_data;
               end else if (r_cnt == CW'(2)) begin
                  r_neg <= w_prod[PW];
                  r_quo <= w_mag;
                  r_rem <= '0;
               end else if (r_cnt == CW'(LAT-1)) begin
                  r_dac_data  <= r_lin ? w_sum : r_a;
                  r_dac_valid <= 1'b1;
                  if (w_end) begin
                     r_fin <= 1'b1;
                  end else begin
                     r_addr <= w_next[AW-1:0];
                     r_k    <= w_adv ? '0 : w_kinc;
                  end
               end else begin
                  r_rem <= w_ge ? SW'(w_shift - {1'b0, r_spd}) : w_shift[SW-1:0];
                  r_quo <= {r_quo[PW-2:0], w_ge};
               end
            end
         end
      end
   end

   assign o_dac_data  = r_dac_data;
   assign o_dac_valid = r_dac_valid;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;

endmodule

// File: tb/tb_aud_dsp_gen2.sv
// Directed bench for aud_dsp_gen2: hand-computed sample sequences for each play mode,
// pause/resume, stop, speed change on a sample boundary and reset mid-computation.
module tb_aud_dsp_gen2;
   localparam int LAT = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, pause, stop, rev, lrck;
   logic [1:0]  mode;
   logic [3:0]  speed;
   logic [19:0] end_addr, sram_addr;
   logic [15:0] sram_data, dac_data;
   logic        dac_valid, busy, done;
   logic [15:0] mem [0:31];
   int          checks = 0;
   int          errors = 0;
   int          max_addr = 0;

   assign sram_data = mem[sram_addr[4:0]];

   aud_dsp_gen2 dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
      .i_mode(mode), .i_speed(speed), .i_reverse(rev), .i_end_addr(end_addr),
      .i_daclrck(lrck), .i_sram_data(sram_data), .o_sram_addr(sram_addr),
      .o_dac_data(dac_data), .o_dac_valid(dac_valid), .o_busy(busy), .o_done(done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [1:0] m, input int s, input bit r, input int e);
      @(negedge clk);
      mode = m; speed = 4'(s); rev = r; end_addr = 20'(e); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_pause();
      @(negedge clk) pause = 1'b1;
      @(negedge clk) pause = 1'b0;
   endtask

   // One LR-clock tick; watches LAT+2 cycles for the valid pulse and done pulse.
   task automatic tick(input string tag, input int exp_val, input bit exp_done, input bit exp_valid);
      int seen, done_at, nval;
      logic [15:0] got;
      seen = -1; done_at = -1; nval = 0; got = '0;
      @(negedge clk) lrck = 1'b1;
      @(negedge clk) lrck = 1'b0;
      for (int i = 1; i <= LAT + 2; i++) begin
         @(negedge clk);
         if (int'(sram_addr) > max_addr) max_addr = int'(sram_addr);
         if (dac_valid) begin
            nval++;
            if (seen < 0) begin
               seen = i;
               got  = dac_data;
            end
         end
         if (done && done_at < 0) done_at = i;
      end
      $display("%s: valid_at=%0d data=%0d done_at=%0d", tag, seen, $signed(got), done_at);
      if (exp_valid) begin
         chk({tag, "/lat"}, seen, LAT);
         chk({tag, "/data"}, $signed(got), exp_val);
         chk({tag, "/done"}, done_at, exp_done ? LAT + 1 : -1);
         chk({tag, "/nvalid"}, nval, 1);
      end else begin
         chk({tag, "/nvalid"}, nval, 0);
         chk({tag, "/data0"}, $signed(dac_data), 0);
      end
   endtask

   initial begin
      int exp_lin1 [8];
      int exp_lin2 [6];
      int exp_hold [6];
      int nv;
      exp_lin1 = '{0, -25, -50, -75, -100, -100, -100, -100};
      exp_lin2 = '{0, 2, 4, 7, 7, 7};
      exp_hold = '{30, 30, 20, 20, 10, 10};
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; rev = 1'b0; lrck = 1'b0;
      mode = 2'd0; speed = 4'd1; end_addr = '0;
      for (int i = 0; i < 32; i++) mem[i] = 16'(i * 100);
      repeat (3) @(negedge clk);
      chk("rst/data", dac_data, 0);
      chk("rst/valid", dac_valid, 0);
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      chk("rst/addr", sram_addr, 0);
      rst = 1'b0;

      go(2'd0, 1, 1'b0, 4);
      chk("fast1/busy", busy, 1);
      for (int i = 0; i < 5; i++) tick($sformatf("fast1[%0d]", i), i * 100, i == 4, 1'b1);
      chk("fast1/busy_end", busy, 0);
      chk("fast1/addr_end", sram_addr, 0);

      max_addr = 0;
      go(2'd0, 3, 1'b0, 10);
      for (int i = 0; i < 4; i++) tick($sformatf("fast3[%0d]", i), i * 300, i == 3, 1'b1);
      chk("fast3/max_addr", max_addr, 10);
      chk("fast3/busy_end", busy, 0);

      mem[0] = 16'd0; mem[1] = -16'sd100;
      go(2'd2, 4, 1'b0, 1);
      for (int i = 0; i < 8; i++) tick($sformatf("lin4[%0d]", i), exp_lin1[i], i == 7, 1'b1);

      mem[1] = 16'd7;
      go(2'd2, 3, 1'b0, 1);
      for (int i = 0; i < 6; i++) tick($sformatf("lin3[%0d]", i), exp_lin2[i], i == 5, 1'b1);

      mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30;
      go(2'd1, 2, 1'b1, 2);
      for (int i = 0; i < 6; i++) tick($sformatf("hold_rev[%0d]", i), exp_hold[i], i == 5, 1'b1);
      chk("hold_rev/busy_end", busy, 0);

      for (int i = 0; i < 32; i++) mem[i] = 16'(i * 100);
      go(2'd0, 1, 1'b0, 10);
      for (int i = 0; i < 3; i++) tick($sformatf("pp[%0d]", i), i * 100, 1'b0, 1'b1);
      pulse_pause();
      chk("pause/busy", busy, 1);
      chk("pause/data", dac_data, 0);
      for (int i = 0; i < 5; i++) tick($sformatf("paused[%0d]", i), 0, 1'b0, 1'b0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      tick("resume", 300, 1'b0, 1'b1);
      pulse_pause();
      @(negedge clk) begin stop = 1'b1; start = 1'b1; end
      @(negedge clk) begin stop = 1'b0; start = 1'b0; end
      chk("stop/busy", busy, 0);
      chk("stop/data", dac_data, 0);

      go(2'd1, 2, 1'b0, 10);
      tick("spd[0]", 0, 1'b0, 1'b1);
      speed = 4'd5;
      tick("spd[1]", 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick($sformatf("spd[%0d]", i + 2), 100, 1'b0, 1'b1);
      tick("spd[7]", 200, 1'b0, 1'b1);

      @(negedge clk) lrck = 1'b1;
      @(negedge clk) lrck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst/data", dac_data, 0);
      chk("midrst/valid", dac_valid, 0);
      chk("midrst/busy", busy, 0);
      chk("midrst/done", done, 0);
      chk("midrst/addr", sram_addr, 0);
      rst = 1'b0;
      nv = 0;
      for (int i = 0; i < LAT + 6; i++) begin
         @(negedge clk);
         if (dac_valid) nv++;
      end
      $display("midrst: valid pulses after reset=%0d", nv);
      chk("midrst/nvalid", nv, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
